// File: rtl/load_extend_ctrl_if.sv
// rtl/load_extend_ctrl_if.sv - load request, data-memory read and writeback response bundle
interface load_extend_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [4:0]  req_rd;

    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;

    logic        stall;

    modport slave (
        input  req_valid, req_addr, req_size, req_signed, req_rd,
        input  mem_rdata, mem_rvalid,
        output req_ready, mem_rd_en, mem_addr,
        output resp_valid, resp_data, resp_rd, resp_err, stall
    );

    modport master (
        output req_valid, req_addr, req_size, req_signed, req_rd,
        output mem_rdata, mem_rvalid,
        input  req_ready, mem_rd_en, mem_addr,
        input  resp_valid, resp_data, resp_rd, resp_err, stall
    );
endinterface

// File: rtl/load_extend_ctrl.sv
// rtl/load_extend_ctrl.sv - MEM-stage load controller: aligned read, timeout, lane select and extension
module load_extend_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                clk,
    input  logic                reset,
    load_extend_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t state_q, state_d;

    logic [1:0]       addr_lo_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      resp_data_q;
    logic [4:0]       resp_rd_q;
    logic [1:0]       resp_err_q;

    logic accept;
    logic req_bad;
    logic data_hit;
    logic timeout_hit;
    logic ready_c;
    logic rd_en_c;
    logic resp_valid_c;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;

    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            SIZE_BYTE: req_bad = 1'b0;
            SIZE_HALF: req_bad = bus.req_addr[0];
            SIZE_WORD: req_bad = (bus.req_addr[1:0] != 2'b00);
            default:   req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ready_c      = 1'b0;
        rd_en_c      = 1'b0;
        resp_valid_c = 1'b0;
        accept       = 1'b0;
        data_hit     = 1'b0;
        timeout_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = req_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                rd_en_c = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Data arriving on the final counted cycle still wins over the timeout.
                if (bus.mem_rvalid) begin
                    data_hit = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo_q)
            2'd0:    byte_lane = bus.mem_rdata[7:0];
            2'd1:    byte_lane = bus.mem_rdata[15:8];
            2'd2:    byte_lane = bus.mem_rdata[23:16];
            default: byte_lane = bus.mem_rdata[31:24];
        endcase
    end

    always_comb begin
        half_lane = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ext_data  = bus.mem_rdata;
        case (size_q)
            SIZE_BYTE: ext_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
            SIZE_HALF: ext_data = {{16{signed_q & half_lane[15]}}, half_lane};
            default:   ext_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_lo_q <= 2'b00;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            rd_q      <= 5'd0;
        end else if (accept) begin
            addr_lo_q <= bus.req_addr[1:0];
            size_q    <= bus.req_size;
            signed_q  <= bus.req_signed;
            rd_q      <= bus.req_rd;
        end
    end

    // Read address is only updated for requests that will actually reach memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= 32'h0;
        end else if (accept && !req_bad) begin
            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == WAIT && !bus.mem_rvalid && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Response registers change only on entry to RESP, so they hold between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_data_q <= 32'h0;
            resp_rd_q   <= 5'd0;
            resp_err_q  <= ERR_OK;
        end else if (accept && req_bad) begin
            resp_data_q <= 32'h0;
            resp_rd_q   <= bus.req_rd;
            resp_err_q  <= ERR_ALIGN;
        end else if (data_hit) begin
            resp_data_q <= ext_data;
            resp_rd_q   <= rd_q;
            resp_err_q  <= ERR_OK;
        end else if (timeout_hit) begin
            resp_data_q <= 32'h0;
            resp_rd_q   <= rd_q;
            resp_err_q  <= ERR_TIMEOUT;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.mem_rd_en  = rd_en_c;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.stall      = (state_q != IDLE);

endmodule
